inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch front end for the 16-bit pipelined CPU.
- Drives the address into the combinational instruction memory (8-bit address, 16-bit data, same-cycle read).
- Captures the returned words into a small prefetch queue and hands {pc, instr} pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects (queue flush), and stops prefetching after fetching a HALT.

Parameters:
ADDR_W, 8, instruction address width; PC wraps modulo 2^ADDR_W.
DATA_W, 16, instruction word width.
DEPTH, 4, prefetch queue entries (power of two, >=2).
HALT_OP, 5'b00001, opcode in instr[15:11] that stops fetching.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
enable  input  1  0 = freeze entire block (no fetch, no pop, no state change); redirect also ignored
start  input  1  one-cycle pulse; leaves IDLE and begins fetching at current PC
i_addr  output  ADDR_W  address to instruction memory (= PC register)
i_data  input  DATA_W  instruction word for i_addr, valid in the same cycle
br_valid  input  1  redirect request (taken branch / jump)
br_addr  input  ADDR_W  redirect target
out_valid  output  1  queue head valid
out_instr  output  DATA_W  queue head instruction
out_pc  output  ADDR_W  address of queue head instruction
out_ready  input  1  decode accepts head this cycle
halted  output  1  high while FSM is in HALTED

Behaviour:
Reset (reset=0, async):
- PC=0, queue count=0, rd/wr pointers=0, FSM=IDLE.
- Outputs: i_addr=0, out_valid=0, out_instr=0, out_pc=0, halted=0.
- Reset mid-operation discards all queue contents immediately.

FSM states: IDLE, RUN, HALTED. All transitions require enable=1.
- IDLE: no fetch. start=1 -> RUN. br_valid ignored.
- RUN:
  - br_valid=1 -> flush queue (count=0), PC<=br_addr, no push this cycle, stay RUN.
  - Otherwise, if count<DEPTH (registered count, before this cycle's pop): push {PC, i_data}, PC<=PC+1 (0xFF -> 0x00).
  - If the pushed word has i_data[15:11]==HALT_OP -> HALTED. The HALT word itself is enqueued.
  - If count==DEPTH: no push and PC holds, even if a pop occurs the same cycle.
- HALTED: no fetch, PC holds at HALT address+1, halted=1.
  - br_valid=1 -> flush, PC<=br_addr, RUN next cycle, halted=0.
  - start is ignored.

Queue:
- out_valid = (count!=0); out_instr/out_pc = head entry, registered.
- Pop when out_valid & out_ready & enable & !br_valid.
- Redirect beats pop: head is discarded, not consumed.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Fetch throughput: one instruction per cycle while not full.
- Latency: word at PC visible at out_* on the cycle after i_addr==PC when the queue was empty.

Test Plan:
- Straight-line fetch: memory[n]=16'h4000+n, start, out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles starting 1 cycle after RUN, out_instr 16'h4000..16'h4003.
- Backpressure: out_ready=0 for 10 cycles -> count saturates at 4, i_addr holds at 0x04. Release out_ready -> pcs 0..7 delivered in order, no gaps or duplicates.
- Redirect with full queue: br_valid=1, br_addr=0x13 -> out_valid=0 next cycle, i_addr=0x13. First delivered out_pc=0x13. The concurrently offered head is not counted as consumed.
- HALT: memory[4]=16'h0800 -> entries 0..4 delivered, halted=1 after pc 4 is pushed, i_addr stays 0x05, nothing more enqueued. Then br_valid with br_addr=0x0D -> halted=0, fetch resumes at 0x0D.
- Wrap and enable: redirect to 0xFE, fetch -> out_pc 0xFE,0xFF,0x00. enable=0 for 3 cycles mid-stream -> i_addr, queue, out_* frozen. Async reset asserted mid-run -> out_valid=0, i_addr=0 without a clock edge.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// inst_fetch : PC sequencer + prefetch queue feeding decode; stops on HALT.
// Rev 1.0
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter int          ADDR_W  = 8,
  parameter int          DATA_W  = 16,
  parameter int          DEPTH   = 4,
  parameter logic [4:0]  HALT_OP = 5'b00001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              out_ready,
  output logic              halted
);

  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [PW:0]         count;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;
  logic [ADDR_W-1:0]   pc_q    [DEPTH];
  logic [DATA_W-1:0]   instr_q [DEPTH];

  logic                redirect;
  logic                push;
  logic                pop;
  logic                halt_hit;
  logic [PW-1:0]       rd_nxt;
  logic [PW-1:0]       wr_nxt;
  logic [PW:0]         cnt_nxt;
  logic [ADDR_W-1:0]   head_pc_nxt;
  logic [DATA_W-1:0]   head_instr_nxt;

  assign i_addr    = pc;
  assign out_valid = (count != '0);

  always_comb begin
    redirect = br_valid && (state != IDLE);
    // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
    push     = (state == RUN) && !br_valid && (count != FULL);
    pop      = out_valid && out_ready && !br_valid;
    halt_hit = push && (i_data[DATA_W-1 -: 5] == HALT_OP);

    rd_nxt  = rd_ptr;
    wr_nxt  = wr_ptr;
    cnt_nxt = count;
    if (redirect) begin
      rd_nxt  = '0;
      wr_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      if (pop)  rd_nxt = rd_ptr + PW'(1);
      if (push) wr_nxt = wr_ptr + PW'(1);
      if (push && !pop)      cnt_nxt = count + (PW+1)'(1);
      else if (!push && pop) cnt_nxt = count - (PW+1)'(1);
    end

    // Next head comes straight from i_data when the word being written lands at the new read slot.
    if (push && (wr_ptr == rd_nxt)) begin
      head_pc_nxt    = pc;
      head_instr_nxt = i_data;
    end else begin
      head_pc_nxt    = pc_q[rd_nxt];
      head_instr_nxt = instr_q[rd_nxt];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_pc    <= '0;
      out_instr <= '0;
      halted    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (enable) begin
      count     <= cnt_nxt;
      rd_ptr    <= rd_nxt;
      wr_ptr    <= wr_nxt;
      out_pc    <= head_pc_nxt;
      out_instr <= head_instr_nxt;
      if (push) begin
        pc_q[wr_ptr]    <= pc;
        instr_q[wr_ptr] <= i_data;
      end
      case (state)
        IDLE: begin
          if (start) state <= RUN;
        end
        RUN: begin
          if (br_valid) begin
            pc <= br_addr;
          end else if (push) begin
            pc <= pc + ADDR_W'(1);
            if (halt_hit) begin
              state  <= HALTED;
              halted <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (br_valid) begin
            pc     <= br_addr;
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// Directed testbench for inst_fetch with a combinational instruction memory model.
module tb_inst_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [7:0]  i_addr;
  logic [15:0] i_data;
  logic        br_valid;
  logic [7:0]  br_addr;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        out_ready;
  logic        halted;

  logic [15:0] mem [256];
  int vectors = 0;
  int miscompares = 0;

  assign i_data = mem[i_addr];

  always #5 clock = ~clock;

  inst_fetch dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .i_addr(i_addr), .i_data(i_data), .br_valid(br_valid), .br_addr(br_addr),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .halted(halted)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", out_valid); end
    vectors++; if (i_addr !== 8'h00) begin miscompares++; $display("FAIL rst_iaddr got %h want 00", i_addr); end
    vectors++; if (out_instr !== 16'h0000) begin miscompares++; $display("FAIL rst_instr got %h want 0000", out_instr); end
    vectors++; if (out_pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc got %h want 00", out_pc); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %0b want 0", halted); end
    reset = 1'b1;
    step();
    // No start yet: must stay idle and not fetch.
    step();
    vectors++; if (out_valid !== 1'b0 || i_addr !== 8'h00) begin miscompares++; $display("FAIL idle valid=%0b iaddr=%h want 0/00", out_valid, i_addr); end
  endtask

  task automatic test_straight();
    out_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++; if (out_valid !== 1'b0 || i_addr !== 8'h00) begin miscompares++; $display("FAIL run_entry valid=%0b iaddr=%h want 0/00", out_valid, i_addr); end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++; if (out_valid !== 1'b1 || out_pc !== 8'(k) || out_instr !== 16'h4000 + 16'(k)) begin
        miscompares++; $display("FAIL straight[%0d] valid=%0b pc=%h instr=%h want 1/%h/%h", k, out_valid, out_pc, out_instr, 8'(k), 16'h4000 + 16'(k));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    br_valid = 1'b1; br_addr = 8'h00;
    step();
    br_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || i_addr !== 8'h00) begin miscompares++; $display("FAIL bp_flush valid=%0b iaddr=%h want 0/00", out_valid, i_addr); end
    repeat (10) step();
    vectors++; if (i_addr !== 8'h04 || out_valid !== 1'b1 || out_pc !== 8'h00) begin
      miscompares++; $display("FAIL bp_full iaddr=%h valid=%0b pc=%h want 04/1/00", i_addr, out_valid, out_pc);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vectors++; if (out_valid !== 1'b1 || out_pc !== 8'(k) || out_instr !== 16'h4000 + 16'(k)) begin
        miscompares++; $display("FAIL bp_drain[%0d] valid=%0b pc=%h instr=%h want 1/%h/%h", k, out_valid, out_pc, out_instr, 8'(k), 16'h4000 + 16'(k));
      end
      step();
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    repeat (6) step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 8'h08) begin miscompares++; $display("FAIL rd_prefill valid=%0b pc=%h want 1/08", out_valid, out_pc); end
    // Head is offered with ready high, but the redirect must discard it.
    out_ready = 1'b1;
    br_valid = 1'b1; br_addr = 8'h13;
    step();
    br_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || i_addr !== 8'h13) begin miscompares++; $display("FAIL rd_flush valid=%0b iaddr=%h want 0/13", out_valid, i_addr); end
    step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 8'h13 || out_instr !== 16'h4013) begin
      miscompares++; $display("FAIL rd_first valid=%0b pc=%h instr=%h want 1/13/4013", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_halt();
    mem[4] = 16'h0800;
    out_ready = 1'b1;
    br_valid = 1'b1; br_addr = 8'h00;
    step();
    br_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (out_valid !== 1'b1 || out_pc !== 8'(k)) begin
        miscompares++; $display("FAIL halt_seq[%0d] valid=%0b pc=%h want 1/%h", k, out_valid, out_pc, 8'(k));
      end
    end
    vectors++; if (out_instr !== 16'h0800 || halted !== 1'b1 || i_addr !== 8'h05) begin
      miscompares++; $display("FAIL halt_word instr=%h halted=%0b iaddr=%h want 0800/1/05", out_instr, halted, i_addr);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    vectors++; if (out_valid !== 1'b0 || halted !== 1'b1 || i_addr !== 8'h05) begin
      miscompares++; $display("FAIL halt_hold valid=%0b halted=%0b iaddr=%h want 0/1/05", out_valid, halted, i_addr);
    end
    br_valid = 1'b1; br_addr = 8'h0D;
    step();
    br_valid = 1'b0;
    vectors++; if (halted !== 1'b0 || i_addr !== 8'h0D || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL halt_exit halted=%0b iaddr=%h valid=%0b want 0/0d/0", halted, i_addr, out_valid);
    end
    step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 8'h0D || out_instr !== 16'h400D) begin
      miscompares++; $display("FAIL halt_resume valid=%0b pc=%h instr=%h want 1/0d/400d", out_valid, out_pc, out_instr);
    end
    mem[4] = 16'h4004;
  endtask

  task automatic test_wrap_enable();
    logic [7:0] exp_pc [3];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
    out_ready = 1'b1;
    br_valid = 1'b1; br_addr = 8'hFE;
    step();
    br_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || out_instr !== {8'h40, exp_pc[k]}) begin
        miscompares++; $display("FAIL wrap[%0d] valid=%0b pc=%h instr=%h want 1/%h/40%h", k, out_valid, out_pc, out_instr, exp_pc[k], exp_pc[k]);
      end
    end
    // Frozen: redirect must be ignored too.
    enable = 1'b0;
    br_valid = 1'b1; br_addr = 8'h55;
    repeat (3) step();
    vectors++; if (i_addr !== 8'h01 || out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 16'h4000) begin
      miscompares++; $display("FAIL freeze iaddr=%h valid=%0b pc=%h instr=%h want 01/1/00/4000", i_addr, out_valid, out_pc, out_instr);
    end
    enable = 1'b1;
    br_valid = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b1 || out_pc !== 8'h01 || i_addr !== 8'h02) begin
      miscompares++; $display("FAIL unfreeze valid=%0b pc=%h iaddr=%h want 1/01/02", out_valid, out_pc, i_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || i_addr !== 8'h00 || halted !== 1'b0) begin
      miscompares++; $display("FAIL async_rst valid=%0b iaddr=%h halted=%0b want 0/00/0", out_valid, i_addr, halted);
    end
    step();
    reset = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0 || i_addr !== 8'h00) begin
      miscompares++; $display("FAIL post_rst_idle valid=%0b iaddr=%h want 0/00", out_valid, i_addr);
    end
  endtask

  initial begin
    for (int n = 0; n < 256; n++) mem[n] = 16'h4000 + 16'(n);
    reset = 1'b0; enable = 1'b1; start = 1'b0;
    br_valid = 1'b0; br_addr = 8'h00; out_ready = 1'b0;
    #12;
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_full();
    test_halt();
    test_wrap_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
